// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-high {g,f,e,d,c,b,a} glyphs and
// digit-count helpers for the scanned display drivers.
package seg7_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0     = 7'b0111111;
    localparam seg_t SEG_1     = 7'b0000110;
    localparam seg_t SEG_2     = 7'b1011011;
    localparam seg_t SEG_3     = 7'b1001111;
    localparam seg_t SEG_4     = 7'b1100110;
    localparam seg_t SEG_5     = 7'b1101101;
    localparam seg_t SEG_6     = 7'b1111101;
    localparam seg_t SEG_7     = 7'b0000111;
    localparam seg_t SEG_8     = 7'b1111111;
    localparam seg_t SEG_9     = 7'b1101111;
    localparam seg_t SEG_A     = 7'b1110111;
    localparam seg_t SEG_B     = 7'b1111100;
    localparam seg_t SEG_C     = 7'b0111001;
    localparam seg_t SEG_D     = 7'b1011110;
    localparam seg_t SEG_E     = 7'b1111001;
    localparam seg_t SEG_F     = 7'b1110001;
    localparam seg_t SEG_BLANK = 7'b0000000;

    localparam int MAX_DIGITS = 8;

    function automatic int max_digits();
        return MAX_DIGITS;
    endfunction

    // Width of a digit index for an n-digit display, clamped to the supported range.
    function automatic int idx_width(input int n);
        int m;
        m = (n > max_digits()) ? max_digits() : n;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-glyph decoder; values 10-15 render only in hex mode
// and are dark in decimal mode, matching the legacy single-digit decoder.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    input  logic       hex_i,
    output seg_t       seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        case (nib_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = hex_i ? SEG_A : SEG_BLANK;
            4'hB: seg_o = hex_i ? SEG_B : SEG_BLANK;
            4'hC: seg_o = hex_i ? SEG_C : SEG_BLANK;
            4'hD: seg_o = hex_i ? SEG_D : SEG_BLANK;
            4'hE: seg_o = hex_i ? SEG_E : SEG_BLANK;
            4'hF: seg_o = hex_i ? SEG_F : SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/display_scan.sv
// N-digit time-multiplexed 7-segment driver: slot divider, digit scan index,
// frame-latched inputs, leading-zero blanking and polarity-adjusted output registers.
module display_scan
    import seg7_pkg::*;
#(
    parameter int N_DIGITS   = 8,
    parameter int CLK_DIV    = 100000,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   iData,
    input  logic [N_DIGITS-1:0]     iDp,
    input  logic                    iHex,
    input  logic                    iLzb,
    input  logic                    iEn,
    output logic [6:0]              oSeg,
    output logic                    oDp,
    output logic [N_DIGITS-1:0]     oAn
);

    localparam int                 IDX_W   = idx_width(N_DIGITS);
    localparam int                 DIV_W   = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]   DIV_MAX = DIV_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_MAX = IDX_W'(N_DIGITS - 1);
    localparam logic               POL     = (ACTIVE_LOW != 0);

    logic [DIV_W-1:0]        div_q, div_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    first_q;
    logic [4*N_DIGITS-1:0]   data_q;
    logic [N_DIGITS-1:0]     dp_q;
    logic                    hex_q;
    logic                    lzb_q;
    logic [6:0]              seg_out_q;
    logic                    dp_out_q;
    logic [N_DIGITS-1:0]     an_out_q;

    logic                    tick;
    logic                    load;
    logic [N_DIGITS-1:0]     blank;
    seg_t                    seg_d;
    logic                    dp_d;
    logic [N_DIGITS-1:0]     an_d;
    seg_t                    dig_seg [N_DIGITS];

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_dec
        seg7_decode u_dec (
            .nib_i (data_q[4*k +: 4]),
            .hex_i (hex_q),
            .seg_o (dig_seg[k])
        );
    end

    // Frame buffers reload at the wrap to digit 0, and once right after reset.
    always_comb begin
        tick  = (div_q == DIV_MAX);
        load  = first_q || (tick && (idx_q == IDX_MAX));
        div_d = tick ? '0 : div_q + DIV_W'(1);
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + IDX_W'(1);
        end
    end

    // A digit is blanked while it and everything to its left is zero with no dp.
    always_comb begin
        logic run;
        run   = lzb_q;
        blank = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            run      = run && (data_q[4*k +: 4] == 4'h0) && !dp_q[k];
            blank[k] = run && (k != 0);
        end
    end

    always_comb begin
        seg_d = SEG_BLANK;
        dp_d  = 1'b0;
        an_d  = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                seg_d   = blank[k] ? SEG_BLANK : dig_seg[k];
                dp_d    = dp_q[k] && !blank[k];
                an_d[k] = iEn;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            idx_q     <= '0;
            first_q   <= 1'b1;
            data_q    <= '0;
            dp_q      <= '0;
            hex_q     <= 1'b0;
            lzb_q     <= 1'b0;
            seg_out_q <= {7{POL}};
            dp_out_q  <= POL;
            an_out_q  <= {N_DIGITS{POL}};
        end else begin
            div_q   <= div_d;
            idx_q   <= idx_d;
            first_q <= 1'b0;
            if (load) begin
                data_q <= iData;
                dp_q   <= iDp;
                hex_q  <= iHex;
                lzb_q  <= iLzb;
            end
            seg_out_q <= seg_d ^ {7{POL}};
            dp_out_q  <= dp_d ^ POL;
            an_out_q  <= an_d ^ {N_DIGITS{POL}};
        end
    end

    assign oSeg = seg_out_q;
    assign oDp  = dp_out_q;
    assign oAn  = an_out_q;

endmodule
